// File: rtl/alu_issue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_issue: instruction FIFO feeding a three-phase ALU issue/capture FSM.  |
// | Optional macro ALU_ISSUE_FWD_EN: operand A forwarded from prev result.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module alu_issue #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_use_prev,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_oper,
  input  logic [W-1:0] alu_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic [2:0]   res_op
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 3 + 2 * W + 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  state_t        state_q;
  logic [W-1:0]  alu_a_q, alu_b_q, res_data_q, prev_res_q;
  logic [2:0]    alu_oper_q, res_op_q;
  logic          res_valid_q;

  logic          full, empty, push, pop;
  logic [2:0]    head_op;
  logic [W-1:0]  head_a, head_b, issue_a;
  logic          head_up;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  // Pops only happen from IDLE, so an entry pushed this cycle is seen next cycle.
  assign pop      = (state_q == S_IDLE) && !empty;

  assign {head_op, head_a, head_b, head_up} = mem_q[rptr_q];

`ifdef ALU_ISSUE_FWD_EN
  assign issue_a = head_up ? prev_res_q : head_a;
`else
  logic unused_head_up;
  assign unused_head_up = head_up;
  assign issue_a = head_a;
`endif

  always_comb begin
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {in_op, in_a, in_b, in_use_prev};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_oper_q  <= '0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      res_valid_q <= 1'b0;
      prev_res_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            alu_a_q    <= issue_a;
            alu_b_q    <= head_b;
            alu_oper_q <= head_op;
            state_q    <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_data_q  <= alu_out;
          res_op_q    <= alu_oper_q;
          res_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            prev_res_q  <= res_data_q;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_oper  = alu_oper_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_issue: directed + random bench with a queue-based result model.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_alu_issue;

  localparam int W = 4;
`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, in_use_prev;
  logic [2:0]   in_op, alu_oper, res_op;
  logic [W-1:0] in_a, in_b, alu_a, alu_b, alu_out, res_data;
  logic         res_valid, res_ready;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         up;
  } ent_t;

  ent_t         exp_q[$];
  logic [W-1:0] m_prev = '0;
  int           checks = 0, failures = 0, n_res = 0;
  bit           last_acc;
  logic [W-1:0] last_res;

  // Downstream ALU stub; the model applies the same arithmetic to the pushed operands.
  function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    int r;
    case (op)
      3'd0:    r = int'(a) + int'(b);
      3'd1:    r = int'(a) - int'(b);
      3'd2:    r = int'(a & b);
      3'd3:    r = int'(a | b);
      3'd4:    r = int'(a ^ b);
      3'd5:    r = int'(a);
      3'd6:    r = int'(b);
      default: r = int'(~a);
    endcase
    return W'(r);
  endfunction

  assign alu_out = alu_fn(alu_oper, alu_a, alu_b);

  alu_issue #(.W(W), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_use_prev(in_use_prev),
    .alu_a(alu_a), .alu_b(alu_b), .alu_oper(alu_oper), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_op(res_op)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, then return just after the rising edge.
  task automatic cyc();
    ent_t e;
    logic [W-1:0] a_eff, ev;
    @(negedge clk);
    last_acc = in_valid && in_ready;
    if (!rst && last_acc) begin
      e = '{op: in_op, a: in_a, b: in_b, up: in_use_prev};
      exp_q.push_back(e);
    end
    if (!rst && res_valid && res_ready) begin
      n_res++;
      last_res = res_data;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(res_valid), 32'(0));
      end else begin
        e = exp_q.pop_front();
        a_eff = (FWD && e.up) ? m_prev : e.a;
        ev = alu_fn(e.op, a_eff, e.b);
        chk("res_data", 32'(res_data), 32'(ev));
        chk("res_op", 32'(res_op), 32'(e.op));
        m_prev = ev;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic up, input int maxw, output bit acc);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_use_prev = up;
    acc = 1'b0;
    for (int k = 0; k < maxw && !acc; k++) begin
      cyc();
      acc = last_acc;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) cyc();
    chk(tag, 32'(exp_q.size()), 32'(0));
  endtask

  task automatic wait_valid(input string tag, input int maxc);
    for (int k = 0; k < maxc && !res_valid; k++) cyc();
    chk(tag, 32'(res_valid), 32'(1));
  endtask

  initial begin
    bit acc;
    int n, lat, n0;
    logic [W-1:0] d, aa, a2;
    logic [2:0] o, op2;

    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    in_use_prev = 1'b0; res_ready = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_res_valid", 32'(res_valid), 32'(0));
    chk("rst_res_data", 32'(res_data), 32'(0));
    chk("rst_res_op", 32'(res_op), 32'(0));
    chk("rst_alu_a", 32'(alu_a), 32'(0));
    chk("rst_alu_b", 32'(alu_b), 32'(0));
    chk("rst_alu_oper", 32'(alu_oper), 32'(0));

    // Single op: 3 + 1 with add, result three cycles after the accept cycle.
    offer(3'd0, W'(3), W'(1), 1'b0, 1, acc);
    chk("single_acc", 32'(acc), 32'(1));
    lat = 1;
    while (!res_valid && lat < 10) begin cyc(); lat++; end
    chk("single_latency", 32'(lat), 32'(3));
    chk("single_data", 32'(res_data), 32'(4));
    chk("single_op", 32'(res_op), 32'(0));
    drain("single_drain");

    // Backpressure: result held for 10 cycles, next op issues after release.
    res_ready = 1'b0;
    offer(3'($urandom), W'($urandom), W'($urandom), 1'b0, 4, acc);
    wait_valid("bp_wait", 10);
    d = res_data; o = res_op; aa = alu_a;
    op2 = 3'($urandom); a2 = W'($urandom);
    offer(op2, a2, W'($urandom), 1'b0, 2, acc);
    chk("bp_second_acc", 32'(acc), 32'(1));
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("bp_valid_hold", 32'(res_valid), 32'(1));
      chk("bp_data_hold", 32'(res_data), 32'(d));
      chk("bp_op_hold", 32'(res_op), 32'(o));
      chk("bp_alu_a_hold", 32'(alu_a), 32'(aa));
    end
    res_ready = 1'b1;
    cyc();
    chk("bp_valid_drop", 32'(res_valid), 32'(0));
    cyc();
    chk("bp_next_oper", 32'(alu_oper), 32'(op2));
    chk("bp_next_a", 32'(alu_a), 32'(a2));
    drain("bp_drain");

    // Full FIFO: one op parked in DONE, four queued, sixth refused.
    res_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      offer(3'($urandom), W'($urandom), W'($urandom), 1'($urandom), 3, acc);
      n += int'(acc);
    end
    chk("full_accepts", 32'(n), 32'(5));
    chk("full_in_ready", 32'(in_ready), 32'(0));
    res_ready = 1'b1;
    drain("full_drain");
    chk("full_in_ready_after", 32'(in_ready), 32'(1));

    // Forwarding: second op takes prev result (4) when enabled, else its own A (0).
    offer(3'd0, W'(3), W'(1), 1'b0, 1, acc);
    offer(3'd0, W'(0), W'(2), 1'b1, 4, acc);
    drain("fwd_drain");
    chk("fwd_res", 32'(last_res), 32'(FWD ? 6 : 2));

    // Reset while an op is in EXEC with two more queued.
    res_ready = 1'b0;
    offer(3'($urandom), W'($urandom), W'($urandom), 1'b0, 4, acc);
    wait_valid("rst_mid_wait", 10);
    for (int i = 0; i < 3; i++) offer(3'($urandom), W'($urandom), W'($urandom), 1'b0, 2, acc);
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_q.delete();
    m_prev = '0;
    chk("rst_mid_res_valid", 32'(res_valid), 32'(0));
    chk("rst_mid_in_ready", 32'(in_ready), 32'(1));
    chk("rst_mid_res_data", 32'(res_data), 32'(0));
    n0 = n_res;
    res_ready = 1'b1;
    repeat (12) cyc();
    chk("rst_mid_no_results", 32'(n_res - n0), 32'(0));

    // Pointer wrap: 12 streamed ops.
    n0 = n_res; n = 0;
    for (int i = 0; i < 12; i++) begin
      offer(3'($urandom), W'($urandom), W'($urandom), 1'($urandom), 6, acc);
      n += int'(acc);
    end
    chk("wrap_accepts", 32'(n), 32'(12));
    drain("wrap_drain");
    chk("wrap_results", 32'(n_res - n0), 32'(12));

    // Random traffic with random result backpressure.
    for (int i = 0; i < 60; i++) begin
      res_ready = 1'($urandom);
      if ($urandom_range(0, 1) == 1)
        offer(3'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1, acc);
      else
        cyc();
    end
    res_ready = 1'b1;
    drain("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
